// File: rtl/hex_display_if.sv
// Bus between a host and the hex display controller: data strobe, error
// mode controls and the registered segment outputs.
interface hex_display_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] data_in;
  logic                data_valid;
  logic                error_set;
  logic                error_clr;
  logic                blank_lz;
  logic [7*DIGITS-1:0] display;
  logic                err_active;

  modport master (
    output data_in, data_valid, error_set, error_clr, blank_lz,
    input  display, err_active
  );

  modport slave (
    input  data_in, data_valid, error_set, error_clr, blank_lz,
    output display, err_active
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment driver: hex decode, leading-zero blanking and a
// blinking "Err" pattern while the error flag is set.
module hex_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic          clk,
  input logic          rst,
  hex_display_if.slave bus
);
  localparam int             CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(BLINK_DIV - 1);
  localparam logic [6:0]     SEG_E      = 7'h79;
  localparam logic [6:0]     SEG_R      = 7'h50;
  localparam logic [6:0]     SEG_BLANK  = 7'h00;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] polarize(input logic [6:0] seg);
    return ACTIVE_LOW ? ~seg : seg;
  endfunction

  logic [4*DIGITS-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] disp_q, disp_d;

  // Data register, error flag and blink timer next state.
  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bus.data_valid) begin
      data_d = bus.data_in;
    end else begin
      data_d = data_q;
    end
    if (bus.error_set) begin
      err_d = 1'b1;
    end else if (bus.error_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    // Entering error mode always starts a fresh show phase; re-sets do not.
    if (!err_q && bus.error_set) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (err_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end else begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
    end
  end

  // Segment pattern for every digit, scanned from the most significant down.
  always_comb begin
    logic       lz_run;
    logic [6:0] code;
    lz_run = 1'b1;
    code   = SEG_BLANK;
    disp_d = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run && (data_q[4*k +: 4] == 4'h0);
      if (err_q) begin
        if (phase_q) begin
          code = SEG_BLANK;
        end else if (k == 2) begin
          code = SEG_E;
        end else if (k == 1 || k == 0) begin
          code = SEG_R;
        end else begin
          code = SEG_BLANK;
        end
      end else if (bus.blank_lz && lz_run && (k != 0)) begin
        code = SEG_BLANK;
      end else begin
        code = hex_seg(data_q[4*k +: 4]);
      end
      disp_d[7*k +: 7] = polarize(code);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      disp_q  <= {DIGITS{polarize(SEG_BLANK)}};
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.display    = disp_q;
  assign bus.err_active = err_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: a 4-digit active-low instance and a
// 6-digit active-high instance, both with a 4-cycle blink half-period.
module tb_hex_display_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   t_a    = 0;
  logic [27:0] a_show, a_blank;
  logic [41:0] b_show;

  always #5 clk = ~clk;

  hex_display_if #(.DIGITS(4)) ifa ();
  hex_display_if #(.DIGITS(6)) ifb ();

  hex_display_ctrl #(.DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  hex_display_ctrl #(.DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  function automatic logic [27:0] exp4(input logic [6:0] c3, input logic [6:0] c2,
                                       input logic [6:0] c1, input logic [6:0] c0);
    return ~{c3, c2, c1, c0};
  endfunction

  function automatic logic [41:0] exp6(input logic [6:0] c5, input logic [6:0] c4,
                                       input logic [6:0] c3, input logic [6:0] c2,
                                       input logic [6:0] c1, input logic [6:0] c0);
    return {c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_a(input logic [15:0] d);
    ifa.data_in    = d;
    ifa.data_valid = 1'b1;
    tick();
    ifa.data_valid = 1'b0;
    tick();
  endtask

  // Time since error entry decides show (first 4 edges) or blank (next 4).
  task automatic blink_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      t_a++;
      check("blink_disp_a", ifa.display, ((((t_a - 1) / 4) % 2) == 0) ? a_show : a_blank);
      check("blink_err_a", ifa.err_active, 1'b1);
    end
  endtask

  initial begin
    a_show  = exp4(7'h00, 7'h79, 7'h50, 7'h50);
    a_blank = 28'hFFFFFFF;
    b_show  = exp6(7'h00, 7'h00, 7'h00, 7'h79, 7'h50, 7'h50);
    ifa.data_in = '0; ifa.data_valid = 1'b0; ifa.error_set = 1'b0;
    ifa.error_clr = 1'b0; ifa.blank_lz = 1'b0;
    ifb.data_in = '0; ifb.data_valid = 1'b0; ifb.error_set = 1'b0;
    ifb.error_clr = 1'b0; ifb.blank_lz = 1'b0;

    tick();
    check("rst_disp_a", ifa.display, 28'hFFFFFFF);
    check("rst_err_a", ifa.err_active, 1'b0);
    check("rst_disp_b", ifb.display, 42'h0);
    rst = 1'b0;
    tick();
    check("post_rst_a", ifa.display, exp4(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    check("post_rst_b", ifb.display, exp6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F));

    // Decode sweep, with a latency check on the first strobe.
    ifa.data_in = 16'h0123; ifa.data_valid = 1'b1;
    ifb.data_in = 24'h012345; ifb.data_valid = 1'b1;
    tick();
    ifa.data_valid = 1'b0; ifb.data_valid = 1'b0;
    check("latency_a", ifa.display, exp4(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    tick();
    check("dec_0123", ifa.display, exp4(7'h3F, 7'h06, 7'h5B, 7'h4F));
    check("dec_b_012345", ifb.display, exp6(7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D));
    latch_a(16'h4567);
    check("dec_4567", ifa.display, exp4(7'h66, 7'h6D, 7'h7D, 7'h07));
    latch_a(16'h89AB);
    check("dec_89AB", ifa.display, exp4(7'h7F, 7'h6F, 7'h77, 7'h7C));
    latch_a(16'hCDEF);
    check("dec_CDEF", ifa.display, exp4(7'h39, 7'h5E, 7'h79, 7'h71));

    // Leading-zero blanking.
    ifa.blank_lz = 1'b1;
    latch_a(16'h0000);
    check("lz_0000", ifa.display, exp4(7'h00, 7'h00, 7'h00, 7'h3F));
    latch_a(16'h00A0);
    check("lz_00A0", ifa.display, exp4(7'h00, 7'h00, 7'h77, 7'h3F));
    latch_a(16'h1000);
    check("lz_1000", ifa.display, exp4(7'h06, 7'h3F, 7'h3F, 7'h3F));
    latch_a(16'h00A0);
    ifa.blank_lz = 1'b0;
    tick();
    check("lz_off", ifa.display, exp4(7'h3F, 7'h3F, 7'h77, 7'h3F));

    // Error entry and blink.
    ifa.error_set = 1'b1; ifb.error_set = 1'b1;
    tick();
    ifa.error_set = 1'b0; ifb.error_set = 1'b0;
    check("err_set_a", ifa.err_active, 1'b1);
    check("err_set_b", ifb.err_active, 1'b1);
    check("err_lat_a", ifa.display, exp4(7'h3F, 7'h3F, 7'h77, 7'h3F));
    t_a = 0;
    blink_check(1);
    check("err_show_b", ifb.display, b_show);
    blink_check(4);
    check("err_blank_b", ifb.display, 42'h0);
    blink_check(4);

    // A repeated error_set mid-blink must not restart the phase.
    ifa.error_set = 1'b1;
    blink_check(1);
    ifa.error_set = 1'b0;
    blink_check(6);

    // Data update during error mode, then exit.
    ifa.data_in = 16'h1234; ifa.data_valid = 1'b1;
    blink_check(1);
    ifa.data_valid = 1'b0;
    ifa.error_clr = 1'b1;
    tick();
    ifa.error_clr = 1'b0;
    check("err_clr_a", ifa.err_active, 1'b0);
    tick();
    check("exit_1234", ifa.display, exp4(7'h06, 7'h5B, 7'h4F, 7'h66));

    // Set and clear together: set wins, and this is a fresh entry.
    ifa.error_set = 1'b1; ifa.error_clr = 1'b1;
    tick();
    ifa.error_set = 1'b0; ifa.error_clr = 1'b0;
    check("set_clr_err", ifa.err_active, 1'b1);
    t_a = 0;
    blink_check(6);

    // Reset mid-blink beats concurrent strobes.
    rst = 1'b1;
    ifa.data_in = 16'h5555; ifa.data_valid = 1'b1; ifa.error_set = 1'b1;
    tick();
    check("rst_mid_disp", ifa.display, 28'hFFFFFFF);
    check("rst_mid_err", ifa.err_active, 1'b0);
    check("rst_mid_err_b", ifb.err_active, 1'b0);
    rst = 1'b0;
    ifa.data_valid = 1'b0; ifa.error_set = 1'b0;
    tick();
    check("rel_disp_a", ifa.display, exp4(7'h3F, 7'h3F, 7'h3F, 7'h3F));
    check("rel_err_a", ifa.err_active, 1'b0);
    check("rel_disp_b", ifb.display, exp6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
